pipeline_ctrl: RTL and testbench

Central stall/flush sequencer for the five-stage RISC-V pipeline. It combines three hazard sources into one consistent set of pipeline-register enables and bubble/flush controls for IF, ID, EX and MEM:

- the ID-stage load-use hazard;
- the EX-stage taken branch or jump (jal/jalr);
- instruction and data memory wait states.

It also runs a data-memory wait FSM with a timeout trap, and keeps saturating performance counters.

---
 rtl/pipeline_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
//   Central stall/flush sequencer for the five-stage RISC-V pipeline. It merges
//   the ID load-use hazard, EX redirects (taken branch, jal, jalr) and
//   instruction/data memory wait states into one set of pipeline-register
//   enables and bubble/flush controls. A data-memory wait FSM traps to a sticky
//   error state on timeout. Two saturating performance counters are kept.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   rs1_id, rs2_id      source registers of the ID instruction
//   rd_ex, memread_ex   destination / load flag of the EX instruction
//   branch_taken_ex     EX instruction redirects the PC
//   imem_valid          fetch word presented to IF/ID is valid
//   dmem_req_mem        MEM instruction accesses data memory
//   dmem_ready          data memory completes the MEM access this cycle
//   pcwrite, ifidwrite, idexwrite, exmemwrite   pipeline register enables
//   ifid_flush          load a NOP into IF/ID
//   clearcontrol        zero the control signals entering ID/EX
//   memwb_bubble        load a bubble into MEM/WB
//   mem_timeout         sticky data-memory timeout trap
//   stall_cycles        saturating count of RUN/DWAIT cycles with pcwrite=0
//   flush_count         saturating count of branch flushes

module pipeline_ctrl #(
  parameter int RS_WIDTH     = 5,
  parameter int DMEM_TIMEOUT = 16,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [RS_WIDTH-1:0]  rs1_id,
  input  logic [RS_WIDTH-1:0]  rs2_id,
  input  logic [RS_WIDTH-1:0]  rd_ex,
  input  logic                 memread_ex,
  input  logic                 branch_taken_ex,
  input  logic                 imem_valid,
  input  logic                 dmem_req_mem,
  input  logic                 dmem_ready,
  output logic                 pcwrite,
  output logic                 ifidwrite,
  output logic                 ifid_flush,
  output logic                 clearcontrol,
  output logic                 idexwrite,
  output logic                 exmemwrite,
  output logic                 memwb_bubble,
  output logic                 mem_timeout,
  output logic [CNT_WIDTH-1:0] stall_cycles,
  output logic [CNT_WIDTH-1:0] flush_count
);

  localparam int WC_W = $clog2(DMEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0]      WAIT_LAST = WC_W'(DMEM_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DWAIT = 2'd1,
    ST_ERR   = 2'd2
  } state_t;

  state_t                state_reg, state_next;
  logic [WC_W-1:0]       wait_cnt_reg, wait_cnt_next;
  logic                  mem_timeout_reg, mem_timeout_next;
  logic [CNT_WIDTH-1:0]  stall_cycles_reg, stall_cycles_next;
  logic [CNT_WIDTH-1:0]  flush_count_reg, flush_count_next;

  logic frozen;
  logic load_use;
  logic flush_evt;
  logic stall_evt;

  // Freeze: an outstanding data access stalls the whole pipeline. In DWAIT the
  // request is already latched downstream, so only dmem_ready matters.
  assign frozen = ((state_reg == ST_RUN)   && dmem_req_mem && !dmem_ready) ||
                  ((state_reg == ST_DWAIT) && !dmem_ready);

  assign load_use = memread_ex && (rd_ex != '0) &&
                    ((rd_ex == rs1_id) || (rd_ex == rs2_id));

  // Next-state logic and combinational control outputs.
  always_comb begin
    state_next       = state_reg;
    wait_cnt_next    = wait_cnt_reg;
    mem_timeout_next = mem_timeout_reg;
    flush_evt        = 1'b0;

    pcwrite      = 1'b1;
    ifidwrite    = 1'b1;
    ifid_flush   = 1'b0;
    clearcontrol = 1'b0;
    idexwrite    = 1'b1;
    exmemwrite   = 1'b1;
    memwb_bubble = 1'b0;

    case (state_reg)
      ST_RUN: begin
        if (frozen) begin
          state_next    = ST_DWAIT;
          wait_cnt_next = '0;
        end
      end
      ST_DWAIT: begin
        if (dmem_ready) begin
          state_next = ST_RUN;
        end else if (wait_cnt_reg == WAIT_LAST) begin
          state_next       = ST_ERR;
          mem_timeout_next = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt_reg + WC_W'(1);
        end
      end
      ST_ERR: begin
        state_next = ST_ERR;
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase

    if ((state_reg == ST_ERR) || frozen) begin
      // Everything holds; MEM/WB receives bubbles.
      pcwrite      = 1'b0;
      ifidwrite    = 1'b0;
      idexwrite    = 1'b0;
      exmemwrite   = 1'b0;
      memwb_bubble = 1'b1;
    end else if (branch_taken_ex) begin
      // Redirect wins over load-use and fetch wait: squash IF/ID and ID/EX.
      ifid_flush   = 1'b1;
      clearcontrol = 1'b1;
      flush_evt    = 1'b1;
    end else if (load_use) begin
      // Hold PC and IF/ID, inject a bubble into EX.
      pcwrite      = 1'b0;
      ifidwrite    = 1'b0;
      clearcontrol = 1'b1;
    end else if (!imem_valid) begin
      // Fetch not ready: keep the PC, feed a NOP into ID, let the rest drain.
      pcwrite    = 1'b0;
      ifid_flush = 1'b1;
    end

    // While reset is held the pipeline is frozen and fully squashed.
    if (!rst) begin
      pcwrite      = 1'b0;
      ifidwrite    = 1'b0;
      idexwrite    = 1'b0;
      exmemwrite   = 1'b0;
      ifid_flush   = 1'b1;
      clearcontrol = 1'b1;
      memwb_bubble = 1'b1;
    end
  end

  assign stall_evt = ((state_reg == ST_RUN) || (state_reg == ST_DWAIT)) && !pcwrite;

  // Saturating counters.
  always_comb begin
    stall_cycles_next = stall_cycles_reg;
    flush_count_next  = flush_count_reg;
    if (stall_evt && (stall_cycles_reg != CNT_MAX)) begin
      stall_cycles_next = stall_cycles_reg + CNT_WIDTH'(1);
    end
    if (flush_evt && (flush_count_reg != CNT_MAX)) begin
      flush_count_next = flush_count_reg + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg        <= ST_RUN;
      wait_cnt_reg     <= '0;
      mem_timeout_reg  <= 1'b0;
      stall_cycles_reg <= '0;
      flush_count_reg  <= '0;
    end else begin
      state_reg        <= state_next;
      wait_cnt_reg     <= wait_cnt_next;
      mem_timeout_reg  <= mem_timeout_next;
      stall_cycles_reg <= stall_cycles_next;
      flush_count_reg  <= flush_count_next;
    end
  end

  assign mem_timeout  = mem_timeout_reg;
  assign stall_cycles = stall_cycles_reg;
  assign flush_count  = flush_count_reg;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Testbench for pipeline_ctrl (DMEM_TIMEOUT=4, CNT_WIDTH=4).
// Each vector drives inputs on the falling edge, checks the combinational
// controls and mem_timeout shortly after, and pushes the expected counter
// values to a scoreboard queue that is popped and compared after the next
// rising edge.

module tb_pipeline_ctrl;

  localparam int RSW = 5;
  localparam int CW  = 4;

  // Control bundle order: {pcwrite, ifidwrite, ifid_flush, clearcontrol,
  //                        idexwrite, exmemwrite, memwb_bubble}
  localparam logic [6:0] C_NORM = 7'b1100110;
  localparam logic [6:0] C_FRZ  = 7'b0000001;
  localparam logic [6:0] C_BR   = 7'b1111110;
  localparam logic [6:0] C_LU   = 7'b0001110;
  localparam logic [6:0] C_IM   = 7'b0110110;
  localparam logic [6:0] C_RST  = 7'b0011001;

  logic           clk;
  logic           rst;
  logic [RSW-1:0] rs1_id, rs2_id, rd_ex;
  logic           memread_ex, branch_taken_ex, imem_valid, dmem_req_mem, dmem_ready;
  logic           pcwrite, ifidwrite, ifid_flush, clearcontrol;
  logic           idexwrite, exmemwrite, memwb_bubble, mem_timeout;
  logic [CW-1:0]  stall_cycles, flush_count;

  pipeline_ctrl #(
    .RS_WIDTH    (RSW),
    .DMEM_TIMEOUT(4),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rs1_id         (rs1_id),
    .rs2_id         (rs2_id),
    .rd_ex          (rd_ex),
    .memread_ex     (memread_ex),
    .branch_taken_ex(branch_taken_ex),
    .imem_valid     (imem_valid),
    .dmem_req_mem   (dmem_req_mem),
    .dmem_ready     (dmem_ready),
    .pcwrite        (pcwrite),
    .ifidwrite      (ifidwrite),
    .ifid_flush     (ifid_flush),
    .clearcontrol   (clearcontrol),
    .idexwrite      (idexwrite),
    .exmemwrite     (exmemwrite),
    .memwb_bubble   (memwb_bubble),
    .mem_timeout    (mem_timeout),
    .stall_cycles   (stall_cycles),
    .flush_count    (flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic           rst;
    logic [RSW-1:0] rs1;
    logic [RSW-1:0] rs2;
    logic [RSW-1:0] rd;
    logic           memread;
    logic           br;
    logic           imv;
    logic           dreq;
    logic           drdy;
    logic [6:0]     ctrl;
    logic           mt;
  } vec_t;

  typedef struct {
    logic [CW-1:0] stall;
    logic [CW-1:0] flush;
  } cnt_t;

  vec_t tbl[$];
  cnt_t sb_q[$];

  int n_vec  = 0;
  int n_fail = 0;
  logic [CW-1:0] m_stall = '0;
  logic [CW-1:0] m_flush = '0;

  function automatic vec_t mk(input logic r, input logic [RSW-1:0] rs1,
                              input logic [RSW-1:0] rs2, input logic [RSW-1:0] rd,
                              input logic mr, input logic br, input logic imv,
                              input logic dreq, input logic drdy,
                              input logic [6:0] ctrl, input logic mt);
    vec_t v;
    v.rst = r; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.memread = mr;
    v.br = br; v.imv = imv; v.dreq = dreq; v.drdy = drdy;
    v.ctrl = ctrl; v.mt = mt;
    return v;
  endfunction

  task automatic apply(input vec_t v, input int idx);
    logic [6:0] ctrl_act;
    cnt_t       exp_c;
    @(negedge clk);
    rst = v.rst; rs1_id = v.rs1; rs2_id = v.rs2; rd_ex = v.rd;
    memread_ex = v.memread; branch_taken_ex = v.br; imem_valid = v.imv;
    dmem_req_mem = v.dreq; dmem_ready = v.drdy;
    #1;
    n_vec++;
    ctrl_act = {pcwrite, ifidwrite, ifid_flush, clearcontrol,
                idexwrite, exmemwrite, memwb_bubble};
    if (ctrl_act !== v.ctrl) begin
      n_fail++;
      $display("FAIL ctrl vec %0d: got %b expected %b", idx, ctrl_act, v.ctrl);
    end
    if (mem_timeout !== v.mt) begin
      n_fail++;
      $display("FAIL mem_timeout vec %0d: got %b expected %b", idx, mem_timeout, v.mt);
    end
    if (!v.rst && (stall_cycles !== '0 || flush_count !== '0)) begin
      n_fail++;
      $display("FAIL reset_counters vec %0d: got stall=%0d flush=%0d expected 0/0",
               idx, stall_cycles, flush_count);
    end
    // Counter model: stalls count outside ERR (mem_timeout=0), flushes count
    // when the redirect pattern (pcwrite=1 with ifid_flush=1) is issued.
    if (!v.rst) begin
      m_stall = '0;
      m_flush = '0;
    end else begin
      if (!v.ctrl[6] && !v.mt && m_stall != 4'hF) m_stall = m_stall + 4'd1;
      if (v.ctrl[6] && v.ctrl[4] && m_flush != 4'hF) m_flush = m_flush + 4'd1;
    end
    exp_c.stall = m_stall;
    exp_c.flush = m_flush;
    sb_q.push_back(exp_c);
    @(posedge clk);
    #1;
    exp_c = sb_q.pop_front();
    if (stall_cycles !== exp_c.stall || flush_count !== exp_c.flush) begin
      n_fail++;
      $display("FAIL counters vec %0d: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
               idx, stall_cycles, flush_count, exp_c.stall, exp_c.flush);
    end
    $display("vec %3d rst=%b ctrl=%b mt=%b stall=%0d flush=%0d",
             idx, v.rst, ctrl_act, mem_timeout, stall_cycles, flush_count);
  endtask

  initial begin
    rst = 1'b0; rs1_id = '0; rs2_id = '0; rd_ex = '0; memread_ex = 1'b0;
    branch_taken_ex = 1'b0; imem_valid = 1'b1; dmem_req_mem = 1'b0; dmem_ready = 1'b1;

    // Reset with toggling inputs, then release.
    tbl.push_back(mk(0, 5'd3, 5'd5, 5'd5, 1, 0, 0, 1, 0, C_RST, 0));
    tbl.push_back(mk(0, 5'd1, 5'd2, 5'd1, 1, 1, 1, 0, 1, C_RST, 0));
    tbl.push_back(mk(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, C_RST, 0));
    tbl.push_back(mk(1, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 1, C_NORM, 0));
    // Load-use on rs2, then rd=0 (no hazard), then load-use on rs1 with fetch wait.
    tbl.push_back(mk(1, 5'd0, 5'd5, 5'd5, 1, 0, 1, 0, 1, C_LU, 0));
    tbl.push_back(mk(1, 5'd1, 5'd2, 5'd9, 0, 0, 1, 0, 1, C_NORM, 0));
    tbl.push_back(mk(1, 5'd0, 5'd0, 5'd0, 1, 0, 1, 0, 1, C_NORM, 0));
    tbl.push_back(mk(1, 5'd7, 5'd1, 5'd7, 1, 0, 0, 0, 1, C_LU, 0));
    // Fetch wait, branch beats load-use, branch beats fetch wait.
    tbl.push_back(mk(1, 5'd1, 5'd2, 5'd3, 0, 0, 0, 0, 1, C_IM, 0));
    tbl.push_back(mk(1, 5'd0, 5'd5, 5'd5, 1, 1, 1, 0, 1, C_BR, 0));
    tbl.push_back(mk(1, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 1, C_BR, 0));
    tbl.push_back(mk(1, 5'd0, 5'd5, 5'd5, 0, 0, 1, 0, 1, C_NORM, 0));
    // Reset, then 3-cycle data wait with hazards ignored; branch acted on at release.
    tbl.push_back(mk(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 1, C_RST, 0));
    tbl.push_back(mk(1, 5'd0, 5'd5, 5'd5, 1, 1, 0, 1, 0, C_FRZ, 0));
    tbl.push_back(mk(1, 5'd0, 5'd0, 5'd0, 0, 1, 1, 1, 0, C_FRZ, 0));
    tbl.push_back(mk(1, 5'd0, 5'd0, 5'd0, 0, 1, 1, 1, 0, C_FRZ, 0));
    tbl.push_back(mk(1, 5'd0, 5'd0, 5'd0, 0, 1, 1, 1, 1, C_BR, 0));
    tbl.push_back(mk(1, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 1, C_NORM, 0));
    // Single-cycle freeze, then a ready access in RUN (no freeze).
    tbl.push_back(mk(1, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 0, C_FRZ, 0));
    tbl.push_back(mk(1, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 1, C_NORM, 0));
    tbl.push_back(mk(1, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 1, C_NORM, 0));

    // Timeout: RUN detection + 4 DWAIT cycles, then ERR; sticky after ready.
    for (int i = 0; i < 5; i++) tbl.push_back(mk(1, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 0, C_FRZ, 0));
    tbl.push_back(mk(1, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 0, C_FRZ, 1));
    tbl.push_back(mk(1, 5'd0, 5'd0, 5'd0, 0, 1, 1, 1, 1, C_FRZ, 1));
    tbl.push_back(mk(1, 5'd0, 5'd5, 5'd5, 1, 0, 0, 0, 1, C_FRZ, 1));
    tbl.push_back(mk(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 1, C_RST, 0));
    tbl.push_back(mk(1, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 1, C_NORM, 0));

    // Saturation: continuous fetch stall for 20 cycles.
    for (int i = 0; i < 20; i++) tbl.push_back(mk(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, C_IM, 0));
    tbl.push_back(mk(1, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 1, C_NORM, 0));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
